// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm: multi-cycle control FSM for a MIPS-subset datapath.
// Define CTRL_TRAP_EN to park unsupported instructions in TRAP instead of retiring them as nops.
module mc_ctrl_fsm #(
  parameter int MEM_WAIT_MAX = 15,
  parameter int ICNT_W       = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [5:0]        opcode,
  input  logic [5:0]        funct,
  input  logic              zero,
  input  logic              mem_ready,
  output logic              pc_we,
  output logic              ir_we,
  output logic              reg_we,
  output logic              mem_req,
  output logic              mem_we,
  output logic [1:0]        reg_dst,
  output logic [1:0]        wd_sel,
  output logic              alu_src_b,
  output logic [1:0]        ext_op,
  output logic [2:0]        alu_op,
  output logic [1:0]        npc_sel,
  output logic [2:0]        state,
  output logic              instr_done,
  output logic              mem_err,
  output logic [ICNT_W-1:0] icnt
);
  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM_RD, MEM_WR, WB, TRAP} state_e;
  localparam logic [2:0] ALU_ADD = 3'd0, ALU_SUB = 3'd1, ALU_OR = 3'd2;
  localparam logic [7:0] WAIT_LAST = 8'(MEM_WAIT_MAX - 1);
`ifdef CTRL_TRAP_EN
  localparam state_e UNSUP_STATE = TRAP;
  localparam bit     UNSUP_DONE  = 1'b0;
`else
  localparam state_e UNSUP_STATE = FETCH;
  localparam bit     UNSUP_DONE  = 1'b1;
`endif
  state_e            state_q, state_d;
  logic [7:0]        wait_q, wait_d;
  logic              mem_err_q;
  logic [ICNT_W-1:0] icnt_q;
  logic is_addu, is_subu, is_jr, is_ori, is_lui, is_lw, is_sw, is_beq, is_j, is_jal;
  logic goes_exec, unsup, in_mem, timeout;
  assign is_addu   = opcode == 6'h00 && funct == 6'h21;
  assign is_subu   = opcode == 6'h00 && funct == 6'h23;
  assign is_jr     = opcode == 6'h00 && funct == 6'h08;
  assign is_ori    = opcode == 6'h0D;
  assign is_lui    = opcode == 6'h0F;
  assign is_lw     = opcode == 6'h23;
  assign is_sw     = opcode == 6'h2B;
  assign is_beq    = opcode == 6'h04;
  assign is_j      = opcode == 6'h02;
  assign is_jal    = opcode == 6'h03;
  assign goes_exec = is_addu | is_subu | is_ori | is_lui | is_lw | is_sw | is_beq;
  assign unsup     = !(goes_exec | is_jr | is_j | is_jal);
  assign in_mem    = state_q == MEM_RD || state_q == MEM_WR;
  // A ready arriving on the limit cycle still completes the access normally.
  assign timeout   = in_mem && !mem_ready && wait_q == WAIT_LAST;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= FETCH;
      wait_q    <= '0;
      mem_err_q <= 1'b0;
      icnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      mem_err_q <= mem_err_q | timeout;
      icnt_q    <= icnt_q + ICNT_W'(instr_done);
    end
  end
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    unique case (state_q)
      FETCH:  state_d = DECODE;
      DECODE: begin
        if (is_jal) state_d = WB;
        else if (goes_exec) state_d = EXEC;
        else if (unsup) state_d = UNSUP_STATE;
        else state_d = FETCH;
      end
      EXEC: begin
        if (is_lw) state_d = MEM_RD;
        else if (is_sw) state_d = MEM_WR;
        else if (is_beq) state_d = FETCH;
        else state_d = WB;
      end
      MEM_RD, MEM_WR: begin
        wait_d = (mem_ready || timeout) ? 8'd0 : wait_q + 8'd1;
        if (mem_ready && state_q == MEM_RD) state_d = WB;
        else if (mem_ready || timeout) state_d = FETCH;
      end
      WB:      state_d = FETCH;
      TRAP:    state_d = TRAP;
      default: state_d = FETCH;
    endcase
  end
  always_comb begin
    {pc_we, ir_we, reg_we, mem_req, mem_we, alu_src_b, instr_done} = '0;
    {reg_dst, wd_sel, ext_op, npc_sel} = '0;
    alu_op = ALU_ADD;
    unique case (state_q)
      FETCH: {ir_we, pc_we} = 2'b11;
      DECODE: begin
        pc_we      = is_j | is_jr;
        npc_sel    = is_j ? 2'd2 : is_jr ? 2'd3 : 2'd0;
        instr_done = is_j | is_jr | (unsup & UNSUP_DONE);
      end
      EXEC, MEM_RD, MEM_WR: begin
        alu_op     = (is_subu | is_beq) ? ALU_SUB : is_ori ? ALU_OR : ALU_ADD;
        alu_src_b  = is_ori | is_lui | is_lw | is_sw;
        ext_op     = is_lui ? 2'd2 : (is_lw | is_sw | is_beq) ? 2'd1 : 2'd0;
        pc_we      = state_q == EXEC && is_beq && zero;
        npc_sel    = (state_q == EXEC && is_beq) ? 2'd1 : 2'd0;
        mem_req    = in_mem;
        mem_we     = state_q == MEM_WR;
        instr_done = (state_q == EXEC && is_beq) || (state_q == MEM_WR && mem_ready);
      end
      WB: begin
        reg_we     = 1'b1;
        instr_done = 1'b1;
        reg_dst    = is_jal ? 2'd2 : opcode == 6'h00 ? 2'd1 : 2'd0;
        wd_sel     = is_jal ? 2'd2 : is_lw ? 2'd1 : 2'd0;
        pc_we      = is_jal;
        npc_sel    = is_jal ? 2'd2 : 2'd0;
      end
      default: ;
    endcase
    if (reset) {pc_we, ir_we, reg_we, mem_req, mem_we, instr_done} = '0;
  end
  assign state   = state_q;
  assign mem_err = mem_err_q;
  assign icnt    = icnt_q;
endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// tb_mc_ctrl_fsm: random instruction stream against a latency/control reference model,
// with a scoreboard monitor that checks each retired or aborted instruction.
module tb_mc_ctrl_fsm;
  localparam int MW = 15;
  logic clk = 1'b0, reset = 1'b1;
  logic [5:0] opcode, funct;
  logic zero, mem_ready;
  logic pc_we, ir_we, reg_we, mem_req, mem_we, alu_src_b, instr_done, mem_err;
  logic [1:0] reg_dst, wd_sel, ext_op, npc_sel;
  logic [2:0] alu_op, state;
  logic [31:0] icnt;

  mc_ctrl_fsm #(.MEM_WAIT_MAX(MW), .ICNT_W(32)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .pc_we(pc_we), .ir_we(ir_we), .reg_we(reg_we),
    .mem_req(mem_req), .mem_we(mem_we), .reg_dst(reg_dst), .wd_sel(wd_sel),
    .alu_src_b(alu_src_b), .ext_op(ext_op), .alu_op(alu_op), .npc_sel(npc_sel),
    .state(state), .instr_done(instr_done), .mem_err(mem_err), .icnt(icnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit abort; int issue; int lat; int nreq;
    bit pc_we, reg_we, mem_we;
    bit [1:0] npc, dst, wd;
    bit [5:0] sel;
    int icnt; bit err;
  } exp_t;

  exp_t sb[$];
  int n_chk = 0, n_fail = 0, cyc = 0;
  int model_cnt = 0;
  bit model_err = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected timing and controls derived from the instruction set rules alone.
  function automatic exp_t model(input logic [5:0] op, input logic [5:0] fn, input bit z, input int w);
    exp_t e;
    e = '{default: 0};
    if (op == 6'h00 && fn == 6'h08) begin e.lat = 2; e.pc_we = 1; e.npc = 3; end
    else if (op == 6'h02) begin e.lat = 2; e.pc_we = 1; e.npc = 2; end
    else if (op == 6'h03) begin e.lat = 3; e.pc_we = 1; e.npc = 2; e.reg_we = 1; e.dst = 2; e.wd = 2; end
    else if (op == 6'h04) begin e.lat = 3; e.pc_we = z; e.npc = 1; e.sel = {3'd1, 1'b0, 2'd1}; end
    else if (op == 6'h00 && fn == 6'h21) begin e.lat = 4; e.reg_we = 1; e.dst = 1; e.sel = {3'd0, 1'b0, 2'd0}; end
    else if (op == 6'h00 && fn == 6'h23) begin e.lat = 4; e.reg_we = 1; e.dst = 1; e.sel = {3'd1, 1'b0, 2'd0}; end
    else if (op == 6'h0D) begin e.lat = 4; e.reg_we = 1; e.sel = {3'd2, 1'b1, 2'd0}; end
    else if (op == 6'h0F) begin e.lat = 4; e.reg_we = 1; e.sel = {3'd0, 1'b1, 2'd2}; end
    else if (op == 6'h23 || op == 6'h2B) begin
      e.sel   = {3'd0, 1'b1, 2'd1};
      e.abort = w >= MW;
      e.nreq  = e.abort ? MW : w + 1;
      e.lat   = e.abort ? MW + 3 : ((op == 6'h23) ? 5 : 4) + w;
      e.reg_we = op == 6'h23;
      e.wd     = (op == 6'h23) ? 2'd1 : 2'd0;
      e.mem_we = op == 6'h2B;
    end
    else e.lat = 2;
    return e;
  endfunction

  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input bit z, input int w);
    exp_t e;
    bit mem;
    e = model(op, fn, z, w);
    mem = op == 6'h23 || op == 6'h2B;
    e.issue = cyc;
    e.icnt  = model_cnt;
    e.err   = model_err;
    if (e.abort) model_err = 1'b1;
    else model_cnt++;
    sb.push_back(e);
    opcode = op; funct = fn; zero = z;
    for (int t = 0; t < e.lat; t++) begin
      mem_ready = mem ? (t >= 3 + w) : 1'($urandom);
      step();
    end
  endtask

  int nreq = 0, nir = 0;
  bit err_seen = 1'b0;
  logic [5:0] m_sel = '0;
  exp_t m_e;

  always @(negedge clk) begin
    if (reset) begin
      nreq = 0; nir = 0; err_seen = 1'b0; m_sel = '0;
    end else begin
      if (mem_err && !err_seen) begin
        err_seen = 1'b1;
        chk("abort_expected", 32'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
          m_e = sb.pop_front();
          chk("abort_kind", 32'(m_e.abort), 1);
          chk("abort_cycles", cyc - m_e.issue, m_e.lat);
          chk("abort_mem_req_cycles", nreq, m_e.nreq);
          chk("abort_ir_we_cycles", nir, 1);
          chk("abort_exec_sel", 32'(m_sel), 32'(m_e.sel));
        end
        nreq = 0; nir = 0; m_sel = '0;
      end
      nreq += int'(mem_req);
      nir  += int'(ir_we);
      if (state == 3'd2) m_sel = {alu_op, alu_src_b, ext_op};
      if (instr_done) begin
        chk("done_expected", 32'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
          m_e = sb.pop_front();
          chk("done_kind", 32'(m_e.abort), 0);
          chk("latency", cyc - m_e.issue + 1, m_e.lat);
          chk("pc_we", 32'(pc_we), 32'(m_e.pc_we));
          chk("npc_sel", 32'(npc_sel), 32'(m_e.npc));
          chk("reg_we", 32'(reg_we), 32'(m_e.reg_we));
          chk("reg_dst", 32'(reg_dst), 32'(m_e.dst));
          chk("wd_sel", 32'(wd_sel), 32'(m_e.wd));
          chk("mem_we", 32'(mem_we), 32'(m_e.mem_we));
          chk("mem_req_cycles", nreq, m_e.nreq);
          chk("ir_we_cycles", nir, 1);
          chk("exec_sel", 32'(m_sel), 32'(m_e.sel));
          chk("icnt", icnt, m_e.icnt);
          chk("mem_err", 32'(mem_err), 32'(m_e.err));
        end
        nreq = 0; nir = 0; m_sel = '0;
      end
    end
  end

  logic [5:0] op_tab [12] = '{6'h00, 6'h00, 6'h00, 6'h0D, 6'h0F, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h03, 6'h3F, 6'h00};
  logic [5:0] fn_tab [12] = '{6'h21, 6'h23, 6'h08, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h3F};
`ifdef CTRL_TRAP_EN
  localparam int NK = 10;
`else
  localparam int NK = 12;
`endif

  initial begin
    opcode = 6'h00; funct = 6'h00; zero = 1'b0; mem_ready = 1'b1; reset = 1'b1;
    step(); step();
    chk("rst_state", 32'(state), 0);
    chk("rst_enables", 32'({pc_we, ir_we, reg_we, mem_req, mem_we}), 0);
    chk("rst_done", 32'(instr_done), 0);
    chk("rst_icnt", icnt, 0);
    chk("rst_mem_err", 32'(mem_err), 0);
    reset = 1'b0;
    #1;
    chk("first_fetch_we", 32'({ir_we, pc_we}), 3);
    run_instr(6'h00, 6'h21, 1'b0, 0);
    run_instr(6'h23, 6'h00, 1'b0, 3);
    run_instr(6'h04, 6'h00, 1'b1, 0);
    run_instr(6'h04, 6'h00, 1'b0, 0);
    run_instr(6'h02, 6'h00, 1'b0, 0);
    run_instr(6'h00, 6'h08, 1'b0, 0);
    run_instr(6'h03, 6'h00, 1'b0, 0);
    run_instr(6'h0D, 6'h00, 1'b0, 0);
    run_instr(6'h0F, 6'h00, 1'b0, 0);
    run_instr(6'h2B, 6'h00, 1'b0, 0);
    run_instr(6'h23, 6'h00, 1'b0, MW - 1);
    for (int i = 0; i < 60; i++) begin
      int k;
      logic [5:0] fn;
      k  = $urandom_range(0, NK - 1);
      fn = (k < 3 || k == 11) ? fn_tab[k] : 6'($urandom);
      run_instr(op_tab[k], fn, 1'($urandom), (k == 5 || k == 6) ? $urandom_range(0, 4) : 0);
    end
    run_instr(6'h2B, 6'h00, 1'b0, MW);
    run_instr(6'h00, 6'h23, 1'b0, 0);
    step();
    chk("sb_drained", sb.size(), 0);
    opcode = 6'h23; mem_ready = 1'b0;
    while (state != 3'd0) step();
    step(); step(); step(); step();
    reset = 1'b1;
    #1;
    chk("midrst_writes", 32'({pc_we, ir_we, reg_we, mem_req, mem_we, instr_done}), 0);
    step();
    chk("midrst_state", 32'(state), 0);
    chk("midrst_icnt", icnt, 0);
    chk("midrst_mem_err", 32'(mem_err), 0);
    reset = 1'b0; model_cnt = 0; model_err = 1'b0;
    run_instr(6'h00, 6'h21, 1'b0, 0);
`ifdef CTRL_TRAP_EN
    opcode = 6'h3F; funct = 6'h00;
    step(); step();
    for (int t = 0; t < 8; t++) begin
      chk("trap_state", 32'(state), 6);
      chk("trap_enables", 32'({pc_we, ir_we, reg_we, mem_req, mem_we, instr_done}), 0);
      step();
    end
    chk("trap_icnt", icnt, model_cnt);
    reset = 1'b1;
    step();
    chk("trap_rst_state", 32'(state), 0);
    reset = 1'b0; model_cnt = 0; model_err = 1'b0;
    run_instr(6'h00, 6'h21, 1'b0, 0);
`else
    run_instr(6'h3F, 6'h00, 1'b0, 0);
    run_instr(6'h00, 6'h3F, 1'b0, 0);
`endif
    step();
    chk("sb_final_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mc_ctrl_fsm.md
Name: mc_ctrl_fsm

Overview:
- Multi-cycle control FSM for the MIPS-subset datapath.
- Consumes the opcode and funct fields split out of the latched instruction register, plus the ALU zero flag and a data-memory ready handshake.
- Sequences PC/IR/register-file/memory write enables and the datapath mux selects state by state.
- Counts retired instructions and aborts on data-memory timeout.

Parameters:
MEM_WAIT_MAX, 15, max cycles spent in MEM_RD/MEM_WR waiting for mem_ready before abort (1..255)
ICNT_W, 32, width of retired-instruction counter

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
opcode  in  6  instr[31:26] from IR
funct  in  6  instr[5:0] from IR
zero  in  1  ALU equal flag (valid in EXEC)
mem_ready  in  1  data memory completes access this cycle
pc_we  out  1  PC write enable
ir_we  out  1  IR write enable
reg_we  out  1  GRF write enable
mem_req  out  1  data memory request (held until mem_ready)
mem_we  out  1  data memory write (qualifies mem_req)
reg_dst  out  2  0=rt, 1=rd, 2=$31
wd_sel  out  2  0=ALU, 1=mem, 2=PC (already PC+4)
alu_src_b  out  1  0=rt data, 1=extended imm
ext_op  out  2  0=zero-ext, 1=sign-ext, 2=imm<<16
alu_op  out  3  0=ADD, 1=SUB, 2=OR
npc_sel  out  2  0=PC+4, 1=branch, 2=j target, 3=rs (jr)
state  out  3  current state (debug)
instr_done  out  1  1-cycle pulse in last cycle of each instruction
mem_err  out  1  sticky timeout flag
icnt  out  ICNT_W  retired instruction count

Behaviour:
- States: FETCH=0, DECODE=1, EXEC=2, MEM_RD=3, MEM_WR=4, WB=5, TRAP=6. State is the only register besides wait counter, mem_err and icnt; all other outputs are combinational from state/opcode/funct/zero.
- Reset: state<=FETCH, wait counter<=0, mem_err<=0, icnt<=0. While reset is high, all enables (pc_we, ir_we, reg_we, mem_req, mem_we) forced 0, instr_done=0. All selects are 0 in any state not driving them.
- Supported: addu (op 0, funct 0x21), subu (0x23), jr (0x08), ori 0x0D, lui 0x0F, lw 0x23, sw 0x2B, beq 0x04, j 0x02, jal 0x03.
- FETCH: ir_we=1, pc_we=1, npc_sel=0 -> DECODE. Always 1 cycle.
- DECODE:
  - j: pc_we, npc_sel=2, done -> FETCH.
  - jr: pc_we, npc_sel=3, done -> FETCH.
  - jal -> WB.
  - Others -> EXEC.
- EXEC:
  - addu/subu: alu_op ADD/SUB, alu_src_b=0 -> WB.
  - ori: OR, src_b=1, ext 0 -> WB.
  - lui: ADD, src_b=1, ext 2 -> WB.
  - lw/sw: ADD, src_b=1, ext 1 -> MEM_RD/MEM_WR.
  - beq: SUB, src_b=0, ext 1, npc_sel=1, pc_we=zero, done -> FETCH.
- MEM_RD/MEM_WR: mem_req=1 (mem_we=1 in MEM_WR). Address selects held as in EXEC.
  - mem_ready=1: lw -> WB; sw asserts done -> FETCH; counter cleared.
  - Else counter++.
  - Counter reaching MEM_WAIT_MAX without ready: mem_err<=1, no writeback, no done -> FETCH.
  - mem_ready on the same cycle as the limit wins (normal completion).
- WB: reg_we=1, done -> FETCH.
  - R-type: reg_dst=1, wd_sel=0.
  - ori/lui: reg_dst=0, wd_sel=0.
  - lw: reg_dst=0, wd_sel=1.
  - jal: reg_dst=2, wd_sel=2, pc_we, npc_sel=2.
- Latency (cycles, zero wait):
  - j/jr: 2.
  - beq/jal: 3.
  - R/ori/lui/sw: 4.
  - lw: 5.
  - Memory wait cycles add 1:1.
- icnt increments (wraps modulo 2^ICNT_W) on every instr_done.
- mem_err is cleared only by reset.
- Reset mid-instruction abandons it: no writes in the reset cycle, FETCH next.

Optional Feature:
CTRL_TRAP_EN
- Defined: an unsupported opcode/funct in DECODE -> TRAP. TRAP asserts no enables and no done, and holds until reset; state output reads 6.
- Undefined: an unsupported instruction acts as nop: DECODE asserts done and returns to FETCH (2 cycles, icnt++); TRAP is unreachable.

Test Plan:
- reset high 2 cycles with mem_ready=1 -> all enables 0, state=0, icnt=0; first post-reset cycle ir_we=pc_we=1.
- addu (op 0, funct 0x21) -> states 0,1,2,5; WB: reg_we=1, reg_dst=1, wd_sel=0; instr_done once; icnt=1.
- lw (0x23) with mem_ready low 3 cycles then high -> MEM_RD for 4 cycles with mem_req=1, then WB with wd_sel=1; total 8 cycles.
- beq (0x04) with zero=1, then again with zero=0 -> EXEC pc_we=1 npc_sel=1, then pc_we=0; both take 3 cycles.
- sw (0x2B) with mem_ready held low, MEM_WAIT_MAX=15 -> 15 MEM_WR cycles, mem_err=1, no instr_done, back to FETCH; icnt unchanged.
- opcode 0x3F -> with CTRL_TRAP_EN: state stuck at 6 until reset; without: 2-cycle nop, icnt++.
